rad_cdc_sync_filt: RTL and testbench
====================================

// Module: rad_cdc_sync_filt
// PURPOSE
//  Multi-channel async-input synchronizer with per-channel glitch filter and edge detect.
//  Each of WIDTH async bits passes through a STAGES-deep sync chain. It is then debounced:
//  a new level must hold FILT_CYCLES consecutive clocks. Sits at chip/block boundaries
//  (straps, IRQs, slow handshakes) in the clk domain.
// PARAMETERS
//  WIDTH        1                  number of independent channels (>=1)
//  STAGES       2                  sync flops per channel (>=2, compile-time check)
//  FILT_CYCLES  4                  consecutive stable samples required to accept new level (>=1)
//  RESET_VAL    '0 [WIDTH-1:0]     per-channel reset value of sync chain and filtered output
//  GLITCH_CNT_W 8                  width of glitch counter (only with RAD_CDC_SYNC_FILT_GLITCH_CNT_EN)
// PORTS
//  clk           in   1             destination clock
//  rst           in   1             async, active-high reset
//  async_i       in   WIDTH         asynchronous inputs
//  sync_o        out  WIDTH         synchronized, filtered levels (registered)
//  rise_o        out  WIDTH         1-cycle pulse when sync_o[i] goes 0->1
//  fall_o        out  WIDTH         1-cycle pulse when sync_o[i] goes 1->0
//  glitch_cnt_o  out  GLITCH_CNT_W  saturating count of rejected glitches (macro only)
//  glitch_clr_i  in   1             sync clear of glitch_cnt_o (macro only)
// BEHAVIOUR
//  - Reset (rst=1, any time incl. mid-qualification): shreg=RESET_VAL, sync_o=RESET_VAL,
//    rise_o=fall_o=0, all states STABLE, cnt=0, glitch_cnt_o=0. No edge pulse on reset release.
//  - Sync chain: shreg[i][0]<=async_i[i], shift each clk; raw[i]=shreg[i][STAGES-1].
//  - Per-channel FSM, cnt width $clog2(FILT_CYCLES+1):
//    STABLE: raw==sync_o -> stay. raw!=sync_o -> if FILT_CYCLES==1 accept now, else QUAL, cnt=1.
//    QUAL:   raw==sync_o -> glitch: STABLE, cnt=0, glitch event.
//            raw!=sync_o && cnt==FILT_CYCLES-1 -> accept: sync_o<=raw, STABLE, cnt=0.
//            else cnt++.
//  - Accept edge also sets rise_o/fall_o for exactly one cycle, coincident with sync_o change.
//  - Latency: async_i change settled before edge 0 -> sync_o changes at edge STAGES+FILT_CYCLES.
//  - Pulse shorter than FILT_CYCLES clocks at raw -> never reaches sync_o.
//  - Channels fully independent; simultaneous accepts on several channels allowed.
//  - rise_o & fall_o never both set for one channel; no pulse without a sync_o change.
// CONFIGURATION
//  RAD_CDC_SYNC_FILT_GLITCH_CNT_EN defined: glitch_cnt_o/glitch_clr_i ports exist.
//    Each cycle, counter += popcount(glitch events across channels), saturates at all-ones.
//    glitch_clr_i=1 -> counter 0 next cycle; clear wins over same-cycle events (dropped).
//  Not defined: ports, counter and popcount absent; filter behaviour identical.
//  Under SIMULATE_METASTABILITY, first-stage randomization applies to each channel
//  independently; the filter must still produce clean sync_o.
// STRUCTURE
//  Package rad_cdc_sync_filt_pkg: typedef enum logic {FILT_STABLE, FILT_QUAL} filt_state_e;
//    function cnt_width(FILT_CYCLES). Parameter legality checks stay in the module.
//  Sub-module rad_cdc_sync_filt_ch: one channel (sync chain + FSM + edge pulses),
//    generate-instantiated WIDTH times. Glitch counter lives in the top module.
//  Sync flops carry (* ASYNC_REG = "true" *).
// TESTING
//  1 WIDTH=4,STAGES=2,FILT=4,RESET_VAL=4'b0101; hold rst then release, inputs = reset
//    value -> sync_o=0101, no rise/fall pulses ever.
//  2 async_i[0] 0->1 held, settled before edge 0 -> sync_o[0]=1 and rise_o[0]=1 at edge 6
//    only; 1->0 -> fall_o[0] at edge 6 after change.
//  3 async_i[1] high for 3 clks then low -> sync_o[1] unchanged, no pulse;
//    glitch_cnt_o=1 (macro on).
//  4 Glitch on ch0 and ch2 same cycle with glitch_cnt_o=254, W=8 -> saturates at 255;
//    glitch_clr_i with a concurrent glitch -> 0.
//  5 rst asserted mid-QUAL (cnt=2) on ch3 -> sync_o=RESET_VAL immediately; after release,
//    a held new level needs the full STAGES+FILT_CYCLES again.
//  6 FILT_CYCLES=1, STAGES=3: a 1-clk-wide raw pulse passes through; sync_o changes at edge 4.

Source files
------------

// File: rtl/rad_cdc_sync_filt_pkg.sv
// Shared types and helpers for the rad_cdc_sync_filt synchronizer/glitch filter.
package rad_cdc_sync_filt_pkg;

  typedef enum logic {
    FILT_STABLE = 1'b0,
    FILT_QUAL   = 1'b1
  } filt_state_e;

  // Counter must hold 0..FILT_CYCLES inclusive.
  function automatic int cnt_width(input int filt_cycles);
    return $clog2(filt_cycles + 1);
  endfunction

endpackage

// File: rtl/rad_cdc_sync_filt_ch.sv
// One channel: STAGES-deep synchronizer, FILT_CYCLES debounce FSM, and edge pulses.
module rad_cdc_sync_filt_ch
  import rad_cdc_sync_filt_pkg::*;
#(
  parameter int   STAGES      = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o
);

  localparam int CW = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  (* ASYNC_REG = "true" *) logic [STAGES-1:0] shreg_q;
  logic [STAGES-1:0] shreg_d;
  logic              raw;

  filt_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_q, sync_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          accept;

  always_comb begin
    shreg_d = {shreg_q[STAGES-2:0], async_i};
`ifdef SIMULATE_METASTABILITY
    // A capturing flop may resolve either way while its input is changing.
    if (async_i != shreg_q[0]) shreg_d[0] = 1'($urandom);
`endif
  end

  assign raw = shreg_q[STAGES-1];

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sync_d   = sync_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_o = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      FILT_STABLE: begin
        if (raw != sync_q) begin
          if (FILT_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            state_d = FILT_QUAL;
            cnt_d   = CW'(1);
          end
        end
      end
      FILT_QUAL: begin
        if (raw == sync_q) begin
          glitch_o = 1'b1;
          state_d  = FILT_STABLE;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          accept  = 1'b1;
          state_d = FILT_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = FILT_STABLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      sync_d = raw;
      rise_d = raw;
      fall_d = ~raw;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; the reset value doubles as the "no edge" reference for
  // the filter, which is why it must match RESET_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= {STAGES{RESET_VAL}};
      state_q <= FILT_STABLE;
      cnt_q   <= '0;
      sync_q  <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/rad_cdc_sync_filt.sv
// Multi-channel async-input synchronizer with glitch filter and edge detect.
// Define RAD_CDC_SYNC_FILT_GLITCH_CNT_EN to add the saturating glitch counter.
module rad_cdc_sync_filt
  import rad_cdc_sync_filt_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter int               FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
`ifdef RAD_CDC_SYNC_FILT_GLITCH_CNT_EN
  , parameter int             GLITCH_CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
`ifdef RAD_CDC_SYNC_FILT_GLITCH_CNT_EN
  , output logic [GLITCH_CNT_W-1:0] glitch_cnt_o,
  input  logic                    glitch_clr_i
`endif
);

  if (WIDTH < 1)       begin : g_bad_width  $error("WIDTH must be >= 1");       end
  if (STAGES < 2)      begin : g_bad_stages $error("STAGES must be >= 2");      end
  if (FILT_CYCLES < 1) begin : g_bad_filt   $error("FILT_CYCLES must be >= 1"); end

  logic [WIDTH-1:0] glitch_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    rad_cdc_sync_filt_ch #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RESET_VAL   (RESET_VAL[i])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .async_i  (async_i[i]),
      .sync_o   (sync_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i]),
      .glitch_o (glitch_w[i])
    );
  end

`ifdef RAD_CDC_SYNC_FILT_GLITCH_CNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  localparam int SW = GLITCH_CNT_W + PW;

  logic [PW-1:0]           pop;
  logic [SW-1:0]           sum;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(glitch_w[i]);
    sum = SW'(glitch_cnt_q) + SW'(pop);
    // Clear wins; events arriving in the clearing cycle are dropped.
    if (glitch_clr_i)                     glitch_cnt_d = '0;
    else if (sum[SW-1:GLITCH_CNT_W] != '0) glitch_cnt_d = '1;
    else                                  glitch_cnt_d = sum[GLITCH_CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) glitch_cnt_q <= '0;
    else     glitch_cnt_q <= glitch_cnt_d;
  end

  assign glitch_cnt_o = glitch_cnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = ^glitch_w;
`endif

endmodule

// File: tb/tb_rad_cdc_sync_filt.sv
// Self-checking bench for rad_cdc_sync_filt: constant vector table, hand sequences,
// and randomized stimulus against a run-length reference model.
module tb_rad_cdc_sync_filt;

  localparam int         W  = 4;
  localparam int         S  = 2;
  localparam int         F  = 4;
  localparam logic [3:0] RV = 4'b0101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] async_v = RV;
  logic [3:0] sync_v, rise_v, fall_v;
  logic       glitch_clr = 1'b0;
  logic       a1 = 1'b0;
  logic       s1, r1, f1;
`ifdef RAD_CDC_SYNC_FILT_GLITCH_CNT_EN
  logic [7:0] gcnt, gcnt1;
`endif

  always #5 clk = ~clk;

  rad_cdc_sync_filt #(
    .WIDTH(W), .STAGES(S), .FILT_CYCLES(F), .RESET_VAL(RV)
`ifdef RAD_CDC_SYNC_FILT_GLITCH_CNT_EN
    , .GLITCH_CNT_W(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .async_i(async_v),
    .sync_o(sync_v), .rise_o(rise_v), .fall_o(fall_v)
`ifdef RAD_CDC_SYNC_FILT_GLITCH_CNT_EN
    , .glitch_cnt_o(gcnt), .glitch_clr_i(glitch_clr)
`endif
  );

  rad_cdc_sync_filt #(
    .WIDTH(1), .STAGES(3), .FILT_CYCLES(1), .RESET_VAL(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .async_i(a1),
    .sync_o(s1), .rise_o(r1), .fall_o(f1)
`ifdef RAD_CDC_SYNC_FILT_GLITCH_CNT_EN
    , .glitch_cnt_o(gcnt1), .glitch_clr_i(1'b0)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: delay line of STAGES samples, then a per-channel run length
  // of samples disagreeing with the output; a run of F flips the output, a
  // shorter run that ends is a glitch.
  logic [3:0] m_q[$];
  logic [3:0] m_out, m_rise, m_fall;
  int         m_run[4];
  int         m_gcnt;

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < S; i++) m_q.push_back(RV);
    m_out = RV; m_rise = '0; m_fall = '0; m_gcnt = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic clr);
    logic [3:0] raw;
    int g;
    raw = m_q.pop_front();
    m_q.push_back(a);
    m_rise = '0; m_fall = '0; g = 0;
    for (int i = 0; i < 4; i++) begin
      if (raw[i] != m_out[i]) begin
        m_run[i]++;
        if (m_run[i] == F) begin
          m_out[i] = raw[i];
          if (raw[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        if (m_run[i] > 0) g++;
        m_run[i] = 0;
      end
    end
    if (clr) m_gcnt = 0;
    else     m_gcnt = (m_gcnt + g > 255) ? 255 : m_gcnt + g;
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic step();
    if (!rst) model_edge(async_v, glitch_clr);
    @(posedge clk);
    #1;
    if (rst) model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, ".sync"}, 32'(sync_v), 32'(m_out));
    check({tag, ".rise"}, 32'(rise_v), 32'(m_rise));
    check({tag, ".fall"}, 32'(fall_v), 32'(m_fall));
`ifdef RAD_CDC_SYNC_FILT_GLITCH_CNT_EN
    check({tag, ".gcnt"}, 32'(gcnt), 32'(m_gcnt));
`endif
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] a, input logic [3:0] s,
                              input logic [3:0] r, input logic [3:0] f);
    vec_t v;
    v.a = a; v.s = s; v.r = r; v.f = f;
    return v;
  endfunction

  task automatic double_glitch();
    async_v = RV ^ 4'b0101;
    step();
    async_v = RV;
    repeat (6) step();
  endtask

  initial begin
    // Reset value held at the inputs; ch0 falls, then rises, each accepted at
    // edge STAGES+FILT_CYCLES = 6 counted from the first sampling edge.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0101, 4'b0101, 4'b0000, 4'b0000));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0100, 4'b0101, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b0100, 4'b0000, 4'b0001));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0100, 4'b0100, 4'b0000, 4'b0000));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0101, 4'b0100, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0101, 4'b0101, 4'b0001, 4'b0000));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0101, 4'b0101, 4'b0000, 4'b0000));

    model_reset();
    repeat (3) step();
    check("rst.sync", 32'(sync_v), 32'(RV));
    check("rst.rise", 32'(rise_v), 32'h0);
    check("rst.fall", 32'(fall_v), 32'h0);
    check("rst.sync1", 32'(s1), 32'h0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      async_v = tbl[k].a;
      step();
      check($sformatf("tbl%0d.sync", k), 32'(sync_v), 32'(tbl[k].s));
      check($sformatf("tbl%0d.rise", k), 32'(rise_v), 32'(tbl[k].r));
      check($sformatf("tbl%0d.fall", k), 32'(fall_v), 32'(tbl[k].f));
    end

    // Three-clock pulse on ch1 is rejected as a glitch.
    async_v = 4'b0111;
    repeat (3) step();
    async_v = RV;
    for (int i = 0; i < 10; i++) begin
      step();
      check("glitch3.sync", 32'(sync_v), 32'(RV));
      check("glitch3.pulse", 32'(rise_v | fall_v), 32'h0);
    end
`ifdef RAD_CDC_SYNC_FILT_GLITCH_CNT_EN
    check("glitch3.gcnt", 32'(gcnt), 32'd1);

    // Saturation: two glitches per event on ch0 and ch2.
    glitch_clr = 1'b1; step(); glitch_clr = 1'b0;
    check("gclr", 32'(gcnt), 32'd0);
    repeat (127) double_glitch();
    check("gcnt254", 32'(gcnt), 32'd254);
    double_glitch();
    check("gcnt_sat", 32'(gcnt), 32'd255);
    double_glitch();
    check("gcnt_sat_hold", 32'(gcnt), 32'd255);
    glitch_clr = 1'b1;
    double_glitch();
    glitch_clr = 1'b0;
    check("gclr_wins", 32'(gcnt), 32'd0);
    step();
    check_model("gclr_after");
`endif

    // Reset in the middle of qualification on ch3.
    async_v = 4'b1101;
    repeat (4) step();
    check("midq.pre_sync", 32'(sync_v), 32'(RV));
    rst = 1'b1;
    #1;
    check("midq.rst_sync", 32'(sync_v), 32'(RV));
    check("midq.rst_pulse", 32'(rise_v | fall_v), 32'h0);
    repeat (2) step();
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_model($sformatf("midq.e%0d", i));
      if (i == 5) check("midq.e5_sync", 32'(sync_v), 32'(RV));
      if (i == 6) begin
        check("midq.e6_sync", 32'(sync_v), 32'h0000000D);
        check("midq.e6_rise", 32'(rise_v), 32'h00000008);
      end
    end

    // Randomized stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) async_v = async_v ^ 4'($urandom);
      glitch_clr = ($urandom_range(15) == 0);
      step();
      check_model($sformatf("rnd%0d", i));
    end
    glitch_clr = 1'b0;

    // FILT_CYCLES=1, STAGES=3: a one-clock pulse passes, visible at edge 4.
    a1 = 1'b1;
    step();
    a1 = 1'b0;
    check("f1.e1", 32'({s1, r1, f1}), 32'b000);
    step(); check("f1.e2", 32'({s1, r1, f1}), 32'b000);
    step(); check("f1.e3", 32'({s1, r1, f1}), 32'b000);
    step(); check("f1.e4", 32'({s1, r1, f1}), 32'b110);
    step(); check("f1.e5", 32'({s1, r1, f1}), 32'b001);
    step(); check("f1.e6", 32'({s1, r1, f1}), 32'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
